// File: rtl/mem_arb.sv
// Two-requester memory-port arbiter: IFU fetches and LSU loads/stores share one
// memory port, one transaction in flight, LSU priority with an IFU starvation guard.
module mem_arb #(
    parameter int unsigned DATA_LEN   = 32,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req,
    input  logic [DATA_LEN-1:0]   ifu_addr,
    output logic                  ifu_gnt,
    output logic                  ifu_rvalid,
    output logic [DATA_LEN-1:0]   ifu_rdata,

    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [DATA_LEN-1:0]   lsu_addr,
    input  logic [DATA_LEN-1:0]   lsu_wdata,
    input  logic [DATA_LEN/8-1:0] lsu_wmask,
    output logic                  lsu_gnt,
    output logic                  lsu_rvalid,
    output logic [DATA_LEN-1:0]   lsu_rdata,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_LEN-1:0]   mem_addr,
    output logic [DATA_LEN-1:0]   mem_wdata,
    output logic [DATA_LEN/8-1:0] mem_wmask,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_LEN-1:0]   mem_rdata
);

    localparam int unsigned MASK_LEN = DATA_LEN / 8;
    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    state_t              state, state_nxt;
    logic                owner, owner_nxt;
    logic [CNT_W-1:0]    starve_cnt, starve_cnt_nxt;

    logic                ifu_gnt_nxt, lsu_gnt_nxt;
    logic                ifu_rvalid_nxt, lsu_rvalid_nxt;
    logic [DATA_LEN-1:0] ifu_rdata_nxt, lsu_rdata_nxt;
    logic                mem_req_nxt, mem_we_nxt;
    logic [DATA_LEN-1:0] mem_addr_nxt, mem_wdata_nxt;
    logic [MASK_LEN-1:0] mem_wmask_nxt;
    logic                lsu_wins;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWNER_IFU;
            starve_cnt <= '0;
            ifu_gnt    <= 1'b0;
            lsu_gnt    <= 1'b0;
            ifu_rvalid <= 1'b0;
            lsu_rvalid <= 1'b0;
            ifu_rdata  <= '0;
            lsu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_cnt_nxt;
            ifu_gnt    <= ifu_gnt_nxt;
            lsu_gnt    <= lsu_gnt_nxt;
            ifu_rvalid <= ifu_rvalid_nxt;
            lsu_rvalid <= lsu_rvalid_nxt;
            ifu_rdata  <= ifu_rdata_nxt;
            lsu_rdata  <= lsu_rdata_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            mem_wmask  <= mem_wmask_nxt;
        end
    end

    // Next-state, arbitration and next values of the output registers
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        starve_cnt_nxt = starve_cnt;
        ifu_gnt_nxt    = 1'b0;
        lsu_gnt_nxt    = 1'b0;
        ifu_rvalid_nxt = 1'b0;
        lsu_rvalid_nxt = 1'b0;
        ifu_rdata_nxt  = ifu_rdata;
        lsu_rdata_nxt  = lsu_rdata;
        mem_req_nxt    = mem_req;
        mem_we_nxt     = mem_we;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        mem_wmask_nxt  = mem_wmask;

        // LSU wins any contest unless the IFU has already lost STARVE_LIM in a row
        lsu_wins = lsu_req && !(ifu_req && (starve_cnt == CNT_LIM));

        case (state)
            IDLE: begin
                if (ifu_req || lsu_req) begin
                    state_nxt   = REQ;
                    mem_req_nxt = 1'b1;
                    if (lsu_wins) begin
                        owner_nxt     = OWNER_LSU;
                        lsu_gnt_nxt   = 1'b1;
                        mem_we_nxt    = lsu_we;
                        mem_addr_nxt  = lsu_addr;
                        mem_wdata_nxt = lsu_wdata;
                        mem_wmask_nxt = lsu_wmask;
                        if (ifu_req && (starve_cnt != CNT_MAX)) begin
                            starve_cnt_nxt = starve_cnt + CNT_W'(1);
                        end
                    end else begin
                        owner_nxt      = OWNER_IFU;
                        ifu_gnt_nxt    = 1'b1;
                        mem_we_nxt     = 1'b0;
                        mem_addr_nxt   = ifu_addr;
                        mem_wdata_nxt  = '0;
                        mem_wmask_nxt  = '0;
                        starve_cnt_nxt = '0;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_nxt   = WAIT;
                    mem_req_nxt = 1'b0;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = RESP;
                    if (owner == OWNER_LSU) begin
                        lsu_rvalid_nxt = 1'b1;
                        lsu_rdata_nxt  = mem_we ? '0 : mem_rdata;
                    end else begin
                        ifu_rvalid_nxt = 1'b1;
                        ifu_rdata_nxt  = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
